// File: rtl/dsp_dot_sequencer_if.sv
// rtl/dsp_dot_sequencer_if.sv - job, operand stream, DSP and result signals of the dot sequencer
interface dsp_dot_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             use_bias;
    logic [47:0]      bias;
    logic             busy;

    logic             in_valid;
    logic             in_ready;
    logic [17:0]      in_a;
    logic [17:0]      in_b;

    logic [1:0]       dsp_op;
    logic [17:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [47:0]      dsp_c;
    logic [47:0]      dsp_p;

    logic             out_valid;
    logic             out_ready;
    logic [47:0]      out_data;

    modport slave (
        input  start, len, use_bias, bias, in_valid, in_a, in_b, dsp_p, out_ready,
        output busy, in_ready, dsp_op, dsp_a, dsp_b, dsp_c, out_valid, out_data
    );

    modport master (
        output start, len, use_bias, bias, in_valid, in_a, in_b, dsp_p, out_ready,
        input  busy, in_ready, dsp_op, dsp_a, dsp_b, dsp_c, out_valid, out_data
    );
endinterface

// File: rtl/dsp_dot_sequencer.sv
// rtl/dsp_dot_sequencer.sv - sequences CLR/MAC/ACC on the DSP MAC unit and returns its accumulator
module dsp_dot_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    dsp_dot_sequencer_if.slave  bus
);
    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_MAC = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_BIAS,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_inc;
    logic [LEN_W-1:0] len_q;
    logic             use_bias_q;
    logic [47:0]      bias_q;
    logic [47:0]      out_data_q;

    logic [1:0]       op_c;
    logic [17:0]      a_c;
    logic [17:0]      b_c;
    logic [47:0]      c_c;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             xfer;

    assign cnt_inc = cnt + LEN_W'(1);
    assign xfer    = (state == S_MAC) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            len_q      <= '0;
            use_bias_q <= 1'b0;
            bias_q     <= '0;
            out_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.start) begin
                len_q      <= bus.len;
                use_bias_q <= bus.use_bias;
                bias_q     <= bus.bias;
                cnt        <= '0;
            end
            if (xfer) begin
                cnt <= cnt_inc;
            end
            // dsp_p already reflects the last MAC/ACC applied at the previous edge
            if (state == S_CAPTURE) begin
                out_data_q <= bus.dsp_p;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        op_c        = OP_NOP;
        a_c         = '0;
        b_c         = '0;
        c_c         = '0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                op_c = OP_CLR;
                if (len_q != '0) begin
                    state_nxt = S_MAC;
                end else if (use_bias_q) begin
                    state_nxt = S_BIAS;
                end else begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_MAC: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    op_c = OP_MAC;
                    a_c  = bus.in_a;
                    b_c  = bus.in_b;
                    if (cnt_inc == len_q) begin
                        state_nxt = use_bias_q ? S_BIAS : S_CAPTURE;
                    end
                end
            end
            S_BIAS: begin
                op_c      = OP_ACC;
                c_c       = bias_q;
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_q;
    assign bus.dsp_op    = op_c;
    assign bus.dsp_a     = a_c;
    assign bus.dsp_b     = b_c;
    assign bus.dsp_c     = c_c;
endmodule

// File: tb/tb_dsp_dot_sequencer.sv
// tb/tb_dsp_dot_sequencer.sv - scoreboard bench for dsp_dot_sequencer with a behavioural DSP model
module tb_dsp_dot_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dsp_dot_sequencer_if #(.LEN_W(8)) bus ();

    dsp_dot_sequencer #(.LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // DSP accumulator: powers up with junk and is untouched by reset
    logic [47:0] p_model = 48'hDEAD_BEEF_1234;
    always @(posedge clk) begin
        case (bus.dsp_op)
            2'b00:   p_model <= 48'd0;
            2'b01:   p_model <= p_model + {30'd0, bus.dsp_a} * {30'd0, bus.dsp_b};
            2'b10:   p_model <= p_model + bus.dsp_c;
            default: p_model <= p_model;
        endcase
    end
    assign bus.dsp_p = p_model;

    int checks = 0;
    int failures = 0;
    logic [47:0] exp_q[$];
    int pushed = 0;
    int popped = 0;

    logic [17:0] pa[256];
    logic [17:0] pb[256];
    int          gap[256];
    logic [1:0]  oplog[$];
    int          busy_cyc;
    int          xfers;
    bit          in_ready_seen;
    logic [47:0] last_c;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got %0h with no job pending", bus.out_data);
            end else begin
                check("sb_result", {16'd0, bus.out_data}, {16'd0, exp_q.pop_front()});
                popped++;
            end
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
        check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        check({tag, "_dsp_op"}, {62'd0, bus.dsp_op}, 64'd3);
        check({tag, "_dsp_ab"}, {28'd0, bus.dsp_a, bus.dsp_b}, 64'd0);
        check({tag, "_dsp_c"}, {16'd0, bus.dsp_c}, 64'd0);
        check({tag, "_out_data"}, {16'd0, bus.out_data}, 64'd0);
    endtask

    task automatic run_job(input int n, input bit ub, input logic [47:0] bs,
                           input bit hold, input bit poke, input bit rnd);
        logic [47:0] e;
        logic [47:0] held;
        int idx;
        int gapleft;
        int cyc;
        bit held_done;
        bit done;
        e = ub ? bs : 48'd0;
        for (int i = 0; i < n; i++) e = e + {30'd0, pa[i]} * {30'd0, pb[i]};
        exp_q.push_back(e);
        pushed++;
        oplog.delete();
        busy_cyc = 0;
        xfers = 0;
        in_ready_seen = 0;
        last_c = '0;
        idx = 0;
        gapleft = gap[0];
        held_done = 0;
        done = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len = n[7:0];
        bus.use_bias = ub;
        bus.bias = bs;
        bus.out_ready = 1'b1;
        if (n > 0 && gapleft == 0) begin
            bus.in_valid = 1'b1; bus.in_a = pa[0]; bus.in_b = pb[0];
        end else begin
            bus.in_valid = 1'b0;
            if (gapleft > 0) gapleft--;
        end
        for (cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            if (cyc > 0 && !bus.busy) begin
                done = 1;
            end else begin
                if (bus.busy) begin
                    busy_cyc++;
                    oplog.push_back(bus.dsp_op);
                    if (bus.dsp_op == 2'b10) last_c = bus.dsp_c;
                end
                if (bus.in_ready) in_ready_seen = 1;
                if (bus.in_ready && bus.in_valid) begin
                    xfers++;
                    idx++;
                    gapleft = (idx < 256) ? gap[idx] : 0;
                end
                if (hold && bus.out_valid && !held_done) begin
                    held = bus.out_data;
                    for (int k = 0; k < 5; k++) begin
                        @(posedge clk); #1;
                        bus.out_ready = 1'b0;
                        bus.start = (k == 2);
                        @(negedge clk);
                        check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
                        check("hold_data", {16'd0, bus.out_data}, {16'd0, held});
                    end
                    held_done = 1;
                end
                @(posedge clk); #1;
                bus.start = poke && bus.in_ready;
                if (poke) bus.len = 8'd7;
                bus.out_ready = (hold && !held_done) ? 1'b0 :
                                (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
                if (idx >= n) begin
                    bus.in_valid = 1'b1;
                    bus.in_a = 18'($urandom);
                    bus.in_b = 18'($urandom);
                end else if (gapleft > 0) begin
                    bus.in_valid = 1'b0;
                    gapleft--;
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_a = pa[idx];
                    bus.in_b = pb[idx];
                end
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL job_timeout: busy still %0d after %0d cycles", bus.busy, cyc);
        end
        check("xfer_count", xfers, n);
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        int xf;
        int n;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.use_bias = 1'b0; bus.bias = '0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin pa[i] = '0; pb[i] = '0; gap[i] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // basic dot product
        pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4; pa[2] = 5; pb[2] = 6;
        run_job(3, 0, 48'd0, 0, 0, 0);
        check("basic_ops", {54'd0, oplog[0], oplog[1], oplog[2], oplog[3], oplog[4]},
              {54'd0, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11});
        check("basic_busy_cycles", busy_cyc, 6);

        // bias with bubbles
        pa[0] = 10; pb[0] = 10; pa[1] = 7; pb[1] = 3; gap[1] = 2;
        run_job(2, 1, 48'd100, 0, 0, 0);
        check("bias_ops", {50'd0, oplog[0], oplog[1], oplog[2], oplog[3], oplog[4], oplog[5], oplog[6]},
              {50'd0, 2'b00, 2'b01, 2'b11, 2'b11, 2'b01, 2'b10, 2'b11});
        check("bias_dsp_c", {16'd0, last_c}, 64'd100);
        gap[1] = 0;

        // zero-length jobs
        run_job(0, 1, 48'hABCD, 0, 0, 0);
        check("zero_bias_no_ready", {63'd0, in_ready_seen}, 64'd0);
        run_job(0, 0, 48'h5555, 0, 0, 0);
        check("zero_nobias_no_ready", {63'd0, in_ready_seen}, 64'd0);

        // backpressure and ignored start
        for (int i = 0; i < 4; i++) begin pa[i] = 18'(i + 11); pb[i] = 18'(3 * i + 1); end
        gap[2] = 1;
        run_job(4, 1, 48'd9, 1, 1, 0);
        gap[2] = 0;
        @(negedge clk);
        check("poke_idle_after", {63'd0, bus.busy}, 64'd0);

        // wrap-around
        for (int i = 0; i < 255; i++) begin pa[i] = 18'h3FFFF; pb[i] = 18'h3FFFF; end
        run_job(255, 0, 48'd0, 0, 0, 0);
        run_job(255, 1, 48'hFFFF_FFFF_FFFF, 0, 0, 0);

        // reset mid-job
        @(posedge clk); #1;
        bus.start = 1'b1; bus.len = 8'd4; bus.use_bias = 1'b1; bus.bias = 48'd5;
        bus.in_valid = 1'b1; bus.in_a = 18'd7; bus.in_b = 18'd9;
        @(posedge clk); #1 bus.start = 1'b0;
        xf = 0;
        for (int k = 0; k < 20 && xf < 2; k++) begin
            @(negedge clk);
            if (bus.in_ready && bus.in_valid) xf++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_checks("midjob_reset");
        @(posedge clk); #1 rst_n = 1'b1; bus.in_valid = 1'b0;
        pa[0] = 2; pb[0] = 3;
        run_job(1, 0, 48'd0, 0, 0, 0);

        // randomized jobs
        for (int j = 0; j < 24; j++) begin
            n = (j % 6 == 5) ? 0 : $urandom_range(1, 20);
            for (int i = 0; i < 256; i++) begin
                pa[i] = 18'($urandom);
                pb[i] = 18'($urandom);
                gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            run_job(n, 1'($urandom_range(0, 1)), {16'($urandom), 32'($urandom)}, 0, 0, 1);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);
        check("sb_count", popped, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
